// File: rtl/decode_stage.sv
// N-wide registered decode stage: fetch group in, uop group out to rename.
// Flags illegal lanes, squashes younger lanes and counts handed-off uops.
package decode_pkg;

  localparam int ARF_IDX = 5;

  typedef enum logic [1:0] {
    RS_INT  = 2'd0,
    RS_INTM = 2'd1,
    RS_MEM  = 2'd2,
    RS_BR   = 2'd3
  } rs_type_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MDU = 2'd1,
    FU_AGU = 2'd2,
    FU_BRU = 2'd3
  } fu_type_t;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_t;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] BR_JAL  = 4'b1000;
  localparam logic [3:0] BR_JALR = 4'b1001;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef struct packed {
    logic               illegal;
    rs_type_t           rs_type;
    fu_type_t           fu_type;
    logic [3:0]         fu_opcode;
    op1_sel_t           op1_sel;
    op2_sel_t           op2_sel;
    logic [31:0]        imm;
    logic [ARF_IDX-1:0] rd;
    logic [ARF_IDX-1:0] rs1;
    logic [ARF_IDX-1:0] rs2;
  } uop_t;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int EN_MDU       = 1,
  parameter int CNT_W        = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DECODE_WIDTH-1:0]                  in_lane_valid,
  input  logic [DECODE_WIDTH-1:0][31:0]            in_inst,
  input  logic [DECODE_WIDTH-1:0][31:0]            in_pc,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DECODE_WIDTH-1:0]                  out_lane_valid,
  output logic [DECODE_WIDTH-1:0]                  out_illegal,
  output logic [DECODE_WIDTH-1:0][31:0]            out_pc,
  output rs_type_t [DECODE_WIDTH-1:0]              out_rs_type,
  output fu_type_t [DECODE_WIDTH-1:0]              out_fu_type,
  output logic [DECODE_WIDTH-1:0][3:0]             out_fu_opcode,
  output op1_sel_t [DECODE_WIDTH-1:0]              out_op1_sel,
  output op2_sel_t [DECODE_WIDTH-1:0]              out_op2_sel,
  output logic [DECODE_WIDTH-1:0][31:0]            out_imm,
  output logic [DECODE_WIDTH-1:0][ARF_IDX-1:0]     out_rd,
  output logic [DECODE_WIDTH-1:0][ARF_IDX-1:0]     out_rs1,
  output logic [DECODE_WIDTH-1:0][ARF_IDX-1:0]     out_rs2,
  output logic [CNT_W-1:0]                         decoded_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic uop_t decode(input logic [31:0] inst);
    uop_t       u;
    logic       ill;
    logic       shift;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    u     = '0;
    ill   = 1'b0;
    shift = 1'b0;
    opc   = inst[6:0];
    f3    = inst[14:12];
    f7    = inst[31:25];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7],
             inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
             inst[20], inst[30:21], 1'b0};
    unique case (1'b1)
      (opc == OPC_LUI), (opc == OPC_AUIPC): begin
        u.op1_sel = (opc == OPC_LUI) ? OP1_ZERO : OP1_PC;
        u.op2_sel = OP2_IMM;
        u.imm     = imm_u;
        u.rd      = inst[11:7];
      end
      (opc == OPC_JAL): begin
        u.rs_type   = RS_BR;
        u.fu_type   = FU_BRU;
        u.fu_opcode = BR_JAL;
        u.op1_sel   = OP1_PC;
        u.op2_sel   = OP2_IMM;
        u.imm       = imm_j;
        u.rd        = inst[11:7];
      end
      (opc == OPC_JALR): begin
        u.rs_type   = RS_BR;
        u.fu_type   = FU_BRU;
        u.fu_opcode = BR_JALR;
        u.op2_sel   = OP2_IMM;
        u.imm       = imm_i;
        u.rd        = inst[11:7];
        u.rs1       = inst[19:15];
      end
      (opc == OPC_BR): begin
        ill         = (f3[2:1] == 2'b01);
        u.rs_type   = RS_BR;
        u.fu_type   = FU_BRU;
        u.fu_opcode = {1'b0, f3};
        u.imm       = imm_b;
        u.rs1       = inst[19:15];
        u.rs2       = inst[24:20];
      end
      (opc == OPC_LD): begin
        ill         = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        u.rs_type   = RS_MEM;
        u.fu_type   = FU_AGU;
        u.fu_opcode = {1'b0, f3};
        u.op2_sel   = OP2_IMM;
        u.imm       = imm_i;
        u.rd        = inst[11:7];
        u.rs1       = inst[19:15];
      end
      (opc == OPC_ST): begin
        ill         = (f3 > 3'b010);
        u.rs_type   = RS_MEM;
        u.fu_type   = FU_AGU;
        u.fu_opcode = {1'b1, f3};
        u.op2_sel   = OP2_IMM;
        u.imm       = imm_s;
        u.rs1       = inst[19:15];
        u.rs2       = inst[24:20];
      end
      (opc == OPC_OPI): begin
        shift = (f3[1:0] == 2'b01);
        if (shift) begin
          if (f3[2])
            ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          else
            ill = (f7 != 7'b0000000);
        end
        u.fu_opcode = {shift & f3[2] & f7[5], f3};
        u.op2_sel   = OP2_IMM;
        u.imm       = imm_i;
        u.rd        = inst[11:7];
        u.rs1       = inst[19:15];
      end
      (opc == OPC_OP): begin
        if (f7 == 7'b0000001) begin
          ill         = (EN_MDU == 0);
          u.rs_type   = RS_INTM;
          u.fu_type   = FU_MDU;
          u.fu_opcode = {1'b0, f3};
        end else begin
          ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          u.fu_opcode = {f7[5], f3};
        end
        u.rd  = inst[11:7];
        u.rs1 = inst[19:15];
        u.rs2 = inst[24:20];
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      u         = '0;
      u.illegal = 1'b1;
    end
    return u;
  endfunction

  uop_t [DECODE_WIDTH-1:0]       uop_d;
  uop_t [DECODE_WIDTH-1:0]       uop_q;
  logic [DECODE_WIDTH-1:0]       lane_valid_d;
  logic [DECODE_WIDTH-1:0]       lane_valid_q;
  logic [DECODE_WIDTH-1:0][31:0] pc_d;
  logic [DECODE_WIDTH-1:0][31:0] pc_q;
  logic                          valid_q;
  logic                          load;
  logic [CNT_W-1:0]              cnt_q;
  logic [CNT_W:0]                pop;
  logic [CNT_W:0]                sum;

  assign in_ready = ~flush & (~valid_q | out_ready);
  assign load     = in_valid & in_ready;

  // decode each lane and kill lanes younger than the first illegal one
  always_comb begin
    logic older_ill;
    uop_t u;
    uop_d        = '0;
    lane_valid_d = '0;
    pc_d         = '0;
    older_ill    = 1'b0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      u = decode(in_inst[i]);
      if (in_lane_valid[i] && !older_ill) begin
        uop_d[i]        = u;
        lane_valid_d[i] = 1'b1;
        pc_d[i]         = in_pc[i];
        older_ill       = u.illegal;
      end
    end
  end

  // output group register with load/hold/drain/flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      lane_valid_q <= '0;
      uop_q        <= '0;
      pc_q         <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      lane_valid_q <= '0;
    end else if (load) begin
      valid_q      <= 1'b1;
      lane_valid_q <= lane_valid_d;
      uop_q        <= uop_d;
      pc_q         <= pc_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // live-lane count of the group at the head
  always_comb begin
    pop = '0;
    for (int i = 0; i < DECODE_WIDTH; i++)
      pop = pop + (CNT_W+1)'(lane_valid_q[i]);
    sum = {1'b0, cnt_q} + pop;
  end

  // saturating count of uops consumed by rename
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (valid_q && out_ready && !flush)
      cnt_q <= (sum > {1'b0, CNT_MAX}) ? CNT_MAX
                                       : sum[CNT_W-1:0];
  end

  // unpack the registered group onto the per-field ports
  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      out_illegal[i]   = uop_q[i].illegal;
      out_rs_type[i]   = uop_q[i].rs_type;
      out_fu_type[i]   = uop_q[i].fu_type;
      out_fu_opcode[i] = uop_q[i].fu_opcode;
      out_op1_sel[i]   = uop_q[i].op1_sel;
      out_op2_sel[i]   = uop_q[i].op2_sel;
      out_imm[i]       = uop_q[i].imm;
      out_rd[i]        = uop_q[i].rd;
      out_rs1[i]       = uop_q[i].rs1;
      out_rs2[i]       = uop_q[i].rs2;
    end
  end

  assign out_valid      = valid_q;
  assign out_lane_valid = lane_valid_q;
  assign out_pc         = pc_q;
  assign decoded_cnt    = cnt_q;

endmodule
